// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receiver
// Purpose: event record, frame state encoding and prefix byte constants.
// Ports: none (package).
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_RLS = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  // Packed as {ext, rls, code} so the raw FIFO word matches the pushed event.
  typedef struct packed {
    logic       ext;
    logic       rls;
    logic [7:0] code;
  } ps2_event_t;

  localparam int PS2_EVENT_W = $bits(ps2_event_t);

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - event FIFO with valid/ready head and overflow pulse
// Purpose: stores decoded events until the consumer takes them.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, wdata       write request and word
//   valid, ready      head present / consumer accepts head
//   rdata             head word (stable until popped)
//   level             occupancy, 0..DEPTH
//   ovf               one-cycle pulse when a push is dropped
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = PS2_EVENT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     valid,
  input  logic                     ready,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = (count != '0) && ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ovf <= push && full && !do_pop;
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign rdata = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver producing scancode events
// Purpose: synchronise and de-glitch the PS/2 lines, decode 11-bit frames,
//   fold E0/F0 prefixes into flags and queue events.
// Option: define PS2_RX_PARITY_CHK_EN to reject bytes with bad odd parity.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ps2clk, ps2dat      raw PS/2 lines
//   ev_valid, ev_ready  event head handshake
//   ev_code/ext/rls     head event fields
//   err                 pulse on frame, parity or timeout error
//   ovf                 pulse when an event is dropped on a full FIFO
//   level               FIFO occupancy
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int TIMEOUT    = 20000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2clk,
  input  logic                          ps2dat,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_rls,
  output logic                          err,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]      FILT_LAST = 4'(FILT_LEN - 1);

  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        filt;
  logic [3:0]  filt_cnt;
  logic        fall;

  ps2_state_t  state;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [TW-1:0] to_cnt;
  logic        pend_ext;
  logic        pend_rls;
  logic        push;
  ps2_event_t  push_ev;
  ps2_event_t  head;
  logic        parity_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2dat};
    end
  end

  // The filtered clock follows the synchronised line only after it has
  // disagreed for FILT_LEN cycles in a row; fall marks the cycle the
  // filtered level is newly low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != filt) begin
        if (filt_cnt == FILT_LAST) begin
          filt     <= clk_sync[1];
          filt_cnt <= '0;
          fall     <= !clk_sync[1];
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

`ifdef PS2_RX_PARITY_CHK_EN
  logic par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if (fall && state == ST_PARITY) begin
      par_bit <= dat_sync[1];
    end
  end

  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      shreg    <= '0;
      to_cnt   <= '0;
      pend_ext <= 1'b0;
      pend_rls <= 1'b0;
      push     <= 1'b0;
      push_ev  <= '0;
      err      <= 1'b0;
    end else begin
      push <= 1'b0;
      err  <= 1'b0;

      if (state == ST_IDLE || fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
        // Line went quiet mid-frame: drop the partial byte.
        state    <= ST_IDLE;
        err      <= 1'b1;
        pend_ext <= 1'b0;
        pend_rls <= 1'b0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!dat_sync[1]) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat_sync[1], shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!dat_sync[1] || !parity_ok) begin
              err      <= 1'b1;
              pend_ext <= 1'b0;
              pend_rls <= 1'b0;
            end else if (shreg == PS2_EXT) begin
              pend_ext <= 1'b1;
            end else if (shreg == PS2_RLS) begin
              pend_rls <= 1'b1;
            end else begin
              push     <= 1'b1;
              push_ev  <= '{ext: pend_ext, rls: pend_rls, code: shreg};
              pend_ext <= 1'b0;
              pend_rls <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .wdata (push_ev),
    .valid (ev_valid),
    .ready (ev_ready),
    .rdata (head),
    .level (level),
    .ovf   (ovf)
  );

  assign ev_code = head.code;
  assign ev_ext  = head.ext;
  assign ev_rls  = head.rls;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - self-checking bench for ps2_rx
// Purpose: drives PS/2 frames and compares events against a byte-level model.
// Ports: none (top-level bench).
module tb_ps2_rx;

  localparam int DEPTH = 8;
  localparam int FILT  = 4;
  localparam int TO    = 1000;
  localparam int HALF  = 16;
`ifdef PS2_RX_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk;
  logic       ps2dat;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_rls;
  logic       err;
  logic       ovf;
  logic [$clog2(DEPTH):0] level;

  ps2_rx #(
    .FILT_LEN   (FILT),
    .TIMEOUT    (TO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2clk   (ps2clk),
    .ps2dat   (ps2dat),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_rls   (ev_rls),
    .err      (err),
    .ovf      (ovf),
    .level    (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;
  int exp_err  = 0;
  int exp_ovf  = 0;
  int rdy_mode = 0;
  bit p_ext    = 1'b0;
  bit p_rls    = 1'b0;
  logic [9:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-level reference: prefixes set flags, errors clear them, others queue.
  task automatic model_frame(input logic [7:0] b, input bit badpar);
    if (badpar && PAR_CHK) begin
      exp_err++;
      p_ext = 1'b0;
      p_rls = 1'b0;
    end else if (b == 8'hE0) begin
      p_ext = 1'b1;
    end else if (b == 8'hF0) begin
      p_rls = 1'b1;
    end else begin
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({p_ext, p_rls, b});
      p_ext = 1'b0;
      p_rls = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (ovf) ovf_cnt++;
    case (rdy_mode)
      0:       ev_ready = 1'b0;
      1:       ev_ready = 1'b1;
      default: ev_ready = 1'($urandom_range(0, 1));
    endcase
    if (!reset && ev_valid) begin
      chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("event_head", {22'd0, ev_ext, ev_rls, ev_code}, {22'd0, exp_q[0]});
        if (ev_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic half_wait(input bit glitch, input logic lvl);
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      ps2clk = ~lvl;
      repeat (2) @(negedge clk);
      ps2clk = lvl;
      repeat (HALF / 2 - 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badpar, input bit glitch,
                            input bit measure, output int lat);
    logic [10:0] f;
    f   = {1'b1, (~^b) ^ badpar, b, 1'b0};
    lat = -1;
    for (int i = 0; i < 11; i++) begin
      ps2dat = f[i];
      half_wait(glitch, 1'b1);
      ps2clk = 1'b0;
      if (i == 10) begin
        model_frame(b, badpar);
        if (measure) begin
          for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ev_valid && lat < 0) lat = k;
          end
        end
      end
      half_wait(glitch, 1'b0);
      ps2clk = 1'b1;
    end
    ps2dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2dat = f[i];
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2dat = 1'b1;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ev_valid) break;
    end
    @(negedge clk);
    #1;
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid_low", 32'(ev_valid), 32'd0);
    rdy_mode = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    bit bad;

    reset  = 1'b1;
    ps2clk = 1'b1;
    ps2dat = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(ev_valid), 32'd0);
    chk("reset_code", 32'({ev_ext, ev_rls, ev_code}), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_err_ovf", 32'({err, ovf}), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single make code and its first-event latency.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, lat);
    chk("latency_cycles", 32'(lat), 32'(2 + FILT + 2));
    chk("level_one", 32'(level), 32'd1);
    drain();

    // Extended break sequence collapses into one event.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0, lat);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, lat);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, lat);
    chk("ext_rls_level", 32'(level), 32'd1);
    drain();

    // Wrong parity.
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, lat);
    chk("badpar_err", 32'(err_cnt), 32'(exp_err));
    drain();

    // Clock stops after four data bits.
    send_partial(8'hA5, 5);
    repeat (TO + 50) @(negedge clk);
    exp_err++;
    p_ext = 1'b0;
    p_rls = 1'b0;
    chk("timeout_err", 32'(err_cnt), 32'(exp_err));
    chk("timeout_level", 32'(level), 32'd0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, lat);
    drain();

    // Overflow with a stalled consumer.
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_frame(8'(i * 7 + 3), 1'b0, 1'b0, 1'b0, lat);
    end
    repeat (10) @(negedge clk);
    chk("ovf_level_full", 32'(level), 32'(DEPTH));
    chk("ovf_pulses", 32'(ovf_cnt), 32'(exp_ovf));
    chk("ovf_expected_one", 32'(ovf_cnt), 32'd1);
    drain();

    // Short glitches on the clock line.
    send_frame(8'h16, 1'b0, 1'b1, 1'b0, lat);
    drain();

    // Reset in the middle of a frame.
    send_partial(8'h55, 3);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_valid", 32'(ev_valid), 32'd0);
    chk("midreset_level", 32'(level), 32'd0);
    reset  = 1'b0;
    ps2clk = 1'b1;
    p_ext  = 1'b0;
    p_rls  = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset_no_err", 32'(err_cnt), 32'(exp_err));

    // Randomised traffic with a random consumer.
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, bad, 1'b0, 1'b0, lat);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    drain();
    chk("final_err_count", 32'(err_cnt), 32'(exp_err));
    chk("final_ovf_count", 32'(ovf_cnt), 32'(exp_ovf));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4, cycles ps2clk must be stable before the filtered level changes (2..15).
REQ-002 SHALL have parameter TIMEOUT, default 20000, clk cycles without a filtered falling edge before a frame in progress is abandoned.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of two, 2..64).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ps2clk, input, 1, raw asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2dat, input, 1, raw asynchronous PS/2 data line.
REQ-008 SHALL have port ev_valid, output, 1, FIFO head holds an event.
REQ-009 SHALL have port ev_ready, input, 1, consumer accepts the head; pop when ev_valid and ev_ready.
REQ-010 SHALL have port ev_code, output, 8, scancode of the head event.
REQ-011 SHALL have port ev_ext, output, 1, head event was preceded by E0.
REQ-012 SHALL have port ev_rls, output, 1, head event was preceded by F0 (break).
REQ-013 SHALL have port err, output, 1, one-cycle pulse on a frame, parity or timeout error.
REQ-014 SHALL have port ovf, output, 1, one-cycle pulse when an event is dropped on a full FIFO.
REQ-015 SHALL have port level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-016 SHALL pass ps2clk and ps2dat through two-flop synchronisers before any use.
REQ-017 SHALL update filtered ps2clk only after the synchronised value differs from it for FILT_LEN consecutive cycles; shorter glitches are ignored.
REQ-018 SHALL sample synchronised ps2dat in the cycle a filtered falling edge is detected.
REQ-019 SHALL run frame FSM IDLE->DATA->PARITY->STOP->IDLE, one transition per sampled bit; DATA holds 8 samples, LSB first.
REQ-020 SHALL stay in IDLE on a sampled start bit of 1, without error.
REQ-021 SHALL check odd parity over data+parity bit (see Configuration).
REQ-022 SHALL discard the byte, pulse err, and return to IDLE on stop bit 0.
REQ-023 SHALL, outside IDLE, count clk cycles since the last filtered falling edge; on reaching TIMEOUT, discard the partial frame, pulse err, and enter IDLE.
REQ-024 SHALL treat a good byte E0 as setting pending ext, F0 as setting pending rls, pushing nothing.
REQ-025 SHALL push any other good byte as {ext,rls,code} in the cycle after the stop sample and clear both pending flags.
REQ-026 SHALL clear both pending flags on any err pulse.
REQ-027 SHALL, with FIFO empty, assert ev_valid exactly 2 cycles after the cycle the stop bit is sampled.
REQ-028 SHALL, on push to a full FIFO without a same-cycle pop, drop the event and pulse ovf; push with simultaneous pop when full SHALL be accepted.
REQ-029 SHALL hold ev_code/ev_ext/ev_rls stable while ev_valid is high and ev_ready is low.
REQ-030 SHALL wrap FIFO pointers modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH.

Reset
REQ-031 SHALL on reset force FSM to IDLE, synchronisers and filtered clock to 1, counters, pending flags and FIFO pointers to 0.
REQ-032 SHALL drive ev_valid=0, ev_code=0, ev_ext=0, ev_rls=0, err=0, ovf=0, level=0 during and after reset.
REQ-033 SHALL abandon any frame in progress at reset without pulsing err.

Configuration
REQ-034 SHALL with PS2_RX_PARITY_CHK_EN defined discard bytes with bad parity and pulse err.
REQ-035 SHALL without PS2_RX_PARITY_CHK_EN sample but ignore the parity bit; such bytes are processed normally.

Structure
REQ-036 SHALL place ps2_event_t (code, ext, rls), the frame state enum and constants PS2_EXT=8'hE0, PS2_RLS=8'hF0 in package ps2_pkg.
REQ-037 SHALL implement the event FIFO as sub-module ps2_fifo, parametrised by FIFO_DEPTH and event width.

Verification
REQ-038 SHALL check frame 0x1C, odd parity good -> one event code=0x1C, ext=0, rls=0, after 2-cycle latency.
REQ-039 SHALL check sequence E0,F0,75 -> one event code=0x75, ext=1, rls=1; level=1.
REQ-040 SHALL check 0x1C with wrong parity -> err pulse, no event (macro on); event code=0x1C (macro off).
REQ-041 SHALL check ps2clk stopping after 4 data bits for TIMEOUT cycles -> err pulse, FSM IDLE, next full frame 0x29 received correctly.
REQ-042 SHALL check FIFO_DEPTH+1 frames with ev_ready=0 -> level=FIFO_DEPTH, one ovf pulse, drain returns first FIFO_DEPTH codes in order.
REQ-043 SHALL check 2-cycle ps2clk glitches (FILT_LEN=4) mid-frame -> no extra bits, byte 0x16 received intact.
